req_encoder: RTL



---
 rtl/req_encoder_pkg.sv | 18 +
 rtl/req_encoder_if.sv | 24 ++
 rtl/req_encoder_pri_find8.sv | 30 +++
 rtl/req_encoder.sv | 88 ++++++++
 4 files changed

// File: rtl/req_encoder_pkg.sv
// Shared widths, state encoding and reset constants for the 8-to-3 sequential request encoder.
package req_encoder_pkg;

    localparam int REQ_N = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_e;

    localparam logic [IDX_W-1:0] LAST_IDX_RST = 3'd7;

    function automatic logic one_hot8(input logic [REQ_N-1:0] v);
        return (v != '0) && ((v & (v - REQ_N'(1))) == '0);
    endfunction

endpackage

// File: rtl/req_encoder_if.sv
// Request/index handshake bundle between a request source/index sink and req_encoder.
interface req_encoder_if;
    import req_encoder_pkg::*;

    logic [REQ_N-1:0] reqIn;
    logic             load;
    logic             busy;
    logic [IDX_W-1:0] encodeOut;
    logic             outValid;
    logic             outReady;
    logic             outLast;
    logic [REQ_N-1:0] pending;

    modport master (
        output reqIn, load, outReady,
        input  busy, encodeOut, outValid, outLast, pending
    );

    modport slave (
        input  reqIn, load, outReady,
        output busy, encodeOut, outValid, outLast, pending
    );

endinterface

// File: rtl/req_encoder_pri_find8.sv
// Combinational find-first-set over 8 bits, searching upward from a start offset with 7->0 wrap.
module pri_find8
    import req_encoder_pkg::*;
(
    input  logic [REQ_N-1:0] vec,
    input  logic [IDX_W-1:0] start,
    output logic [IDX_W-1:0] idx,
    output logic             found,
    output logic             only_one
);

    logic [IDX_W-1:0] pos;

    // Walk offsets from farthest to nearest so the nearest set bit wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int i = REQ_N - 1; i >= 0; i--) begin
            pos = start + IDX_W'(i);
            if (vec[pos]) begin
                idx   = pos;
                found = 1'b1;
            end
        end
    end

    assign only_one = one_hot8(vec);

endmodule

// File: rtl/req_encoder.sv
// Sequential 8-to-3 request encoder: snapshots reqIn and serialises its set bits as indices.
// Build option: define REQ_ENCODER_ROUND_ROBIN_EN to start each search after the last served index.
module req_encoder
    import req_encoder_pkg::*;
(
    input logic           clk,
    input logic           rst_n,
    req_encoder_if.slave  bus
);

`ifdef REQ_ENCODER_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    state_e           state_q, state_nxt;
    logic [REQ_N-1:0] pend_q, pend_nxt;
    logic [IDX_W-1:0] last_q, last_nxt;
    logic [IDX_W-1:0] enc_q;
    logic             olast_q, ovld_q, busy_q;
    logic             accept;

    logic [IDX_W-1:0] f_start, f_idx;
    logic             f_found, f_one;

    assign accept = (state_q == SERVE) && bus.outReady;

    always_comb begin
        state_nxt = state_q;
        pend_nxt  = pend_q;
        last_nxt  = last_q;
        case (state_q)
            IDLE: begin
                if (bus.load && (bus.reqIn != '0)) begin
                    pend_nxt  = bus.reqIn;
                    state_nxt = SERVE;
                end
            end
            SERVE: begin
                if (accept) begin
                    pend_nxt = pend_q & ~(REQ_N'(1) << enc_q);
                    last_nxt = enc_q;
                    if (olast_q) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The finder looks at next-cycle pending so the offered index comes straight from a flop.
    assign f_start = RR_EN ? last_nxt + IDX_W'(1) : '0;

    pri_find8 u_find (
        .vec      (pend_nxt),
        .start    (f_start),
        .idx      (f_idx),
        .found    (f_found),
        .only_one (f_one)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= '0;
            last_q  <= LAST_IDX_RST;
            enc_q   <= '0;
            olast_q <= 1'b0;
            ovld_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            pend_q  <= pend_nxt;
            last_q  <= last_nxt;
            enc_q   <= f_idx;
            olast_q <= f_found && f_one;
            ovld_q  <= (state_nxt == SERVE);
            busy_q  <= (state_nxt == SERVE);
        end
    end

    assign bus.encodeOut = enc_q;
    assign bus.outLast   = olast_q;
    assign bus.outValid  = ovld_q;
    assign bus.busy      = busy_q;
    assign bus.pending   = pend_q;

endmodule
